stream_mux_rr: RTL
==================

Name: stream_mux_rr

Overview:
- Parametrised successor to the team's combinational 2:1 select: an NCH-input, WIDTH-bit registered stream multiplexer.
- Each input is a valid/ready channel; one output valid/ready channel carries the data.
- Two modes: fixed select (software/FSM-driven `sel`) and round-robin arbitration across requesting channels.
- Sits between game-logic producers (paddle, ball, score updaters) and a single shared consumer such as the VGA draw or register-update path.

Parameters:
- WIDTH, 8, data bits per channel.
- NCH, 4, number of input channels (2..16).
- SEL_W, 2, select/index width; must equal clog2(NCH), with a minimum of 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NCH  per-channel valid.
- in_ready  out  NCH  per-channel ready; combinational.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SEL_W  channel index used in fixed mode.
- out_data  out  WIDTH  registered output data.
- out_ch  out  SEL_W  index of the channel that supplied out_data.
- out_valid  out  1  output holds a word.
- out_ready  in  1  consumer accepts the word.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
  - in_ready=0 whenever rst_n=0.
- Output stage is a single register.
  - load = !out_valid || out_ready, so back-to-back transfers sustain 1 word/cycle.
  - Latency from input handshake to out_valid is 1 cycle.
- Channel choice (combinational, evaluated each cycle):
  - Fixed mode: chosen = sel. If sel >= NCH (non-power-of-2 NCH), no channel is chosen.
  - Round-robin mode: chosen = first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, … mod NCH. If no channel is valid, none is chosen.
- in_ready[i] = load && (chosen==i). At most one bit is ever set.
  - in_ready does not depend on in_valid[i] in fixed mode.
  - In round-robin mode it is set only for a valid channel.
- Transfer on channel i when in_valid[i] && in_ready[i]:
  - next cycle out_data = channel i data, out_ch = i, out_valid = 1.
  - In round-robin mode, rr_ptr <= (i+1) mod NCH.
- If out_valid && out_ready && no transfer, out_valid <= 0; out_data and out_ch hold their values.
- If out_valid && !out_ready, out_data, out_ch and out_valid hold stable. No input is accepted.
- rr_ptr updates only on a round-robin-mode transfer. It holds across fixed-mode operation and mode switches.
- mode and sel changes take effect on the same cycle's choice. A word already in the output register is unaffected.
- Reset asserted mid-stream drops the held word immediately (out_valid=0). No partial state survives.
- Fairness: with all NCH channels continuously valid and out_ready=1, round-robin grants 0,1,…,NCH-1,0,… with no gaps.

Decomposition:
- Shared package/header holds:
  - MODE_FIXED=1'b0, MODE_RR=1'b1;
  - a clog2 constant function;
  - the channel-slice convention for in_data.
- One natural sub-module: rr_pick.
  - Purely combinational rotate-priority picker: inputs req[NCH] and ptr[SEL_W]; outputs gnt_idx and gnt_any.
  - Reused later by other arbiters.
- Top-level holds the output register, rr_ptr and the handshake logic.

Test Plan:
- Reset: hold rst_n=0 with all inputs valid → out_valid=0, out_data=0, out_ch=0, in_ready=0000. Release rst_n → first transfer appears 1 cycle after the handshake.
- Fixed mode, NCH=4, WIDTH=8, sel=2, ch2 streams A0,A1,A2, out_ready=1 → out_data A0,A1,A2 on consecutive cycles with out_ch=2. in_ready = 0100 every cycle.
- Backpressure: out_ready=0 for 3 cycles while holding word 5A → out_data=5A and out_valid=1 stable. in_ready=0000. out_ready=1 resumes 1 word/cycle with no loss or duplication.
- Round-robin, all four channels continuously valid, out_ready=1 → out_ch sequence 0,1,2,3,0,1,… Then only ch1 and ch3 valid from rr_ptr=2 → sequence 3,1,3,1.
- Mode switch: after round-robin grant to ch1 (rr_ptr=2), switch to fixed sel=0 for 2 words, then back to round-robin with ch0..3 valid → next out_ch=2, because rr_ptr held.
- Mid-stream reset with out_valid=1, out_data=C3 → out_valid drops to 0 asynchronously. After release, round-robin restarts at ch0.

Source files
------------

// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the stream_mux_rr family: mode encodings, index-width
// helper and the packed channel-slice convention used on in_data.
package stream_mux_rr_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Index width for n channels, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < n) r++;
      end
      return (r < 1) ? 1 : r;
   endfunction

   // Channel ch occupies bits [ch*width +: width] of a packed channel bus.
   function automatic int ch_lo(input int ch, input int width);
      return ch * width;
   endfunction

endpackage

// File: rtl/stream_mux_rr_rr_pick.sv
// Combinational rotate-priority picker: grants the first requester found when
// scanning from ptr upward, wrapping modulo NCH.
module rr_pick #(
   parameter int NCH   = 4,
   parameter int SEL_W = 2
) (
   input  logic [NCH-1:0]   req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             gnt_any
);

   int idx;

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = 0;
      // Scan farthest-first so the nearest requester to ptr is written last and wins.
      for (int k = NCH - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NCH;
         if (req[idx]) begin
            gnt_idx = SEL_W'(idx);
            gnt_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// NCH-input registered stream multiplexer with fixed-select and round-robin
// modes; one output register gives single-cycle latency at one word per cycle.
module stream_mux_rr
   import stream_mux_rr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   parameter int SEL_W = clog2_min1(NCH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   input  logic                 mode,
   input  logic [SEL_W-1:0]     sel,
   output logic [WIDTH-1:0]     out_data,
   output logic [SEL_W-1:0]     out_ch,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam logic [SEL_W:0]   NCH_L  = (SEL_W + 1)'(NCH);
   localparam logic [SEL_W-1:0] LAST_L = SEL_W'(NCH - 1);

   logic             load;
   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W-1:0] rr_next;
   logic [SEL_W-1:0] pick_idx;
   logic             pick_any;
   logic [SEL_W-1:0] chosen;
   logic             chosen_any;
   logic [NCH-1:0]   grant;
   logic             xfer;
   logic [WIDTH-1:0] xfer_data;

   rr_pick #(
      .NCH   (NCH),
      .SEL_W (SEL_W)
   ) u_pick (
      .req     (in_valid),
      .ptr     (rr_ptr),
      .gnt_idx (pick_idx),
      .gnt_any (pick_any)
   );

   assign load = !out_valid || out_ready;

   always_comb begin
      chosen     = sel;
      chosen_any = ({1'b0, sel} < NCH_L);
      if (mode == MODE_RR) begin
         chosen     = pick_idx;
         chosen_any = pick_any;
      end
   end

   // Grant is gated by rst_n so no channel sees ready while the block is held in reset.
   always_comb begin
      grant     = '0;
      xfer_data = '0;
      for (int i = 0; i < NCH; i++) begin
         grant[i] = rst_n && load && chosen_any && (chosen == SEL_W'(i));
         if (grant[i]) xfer_data = in_data[ch_lo(i, WIDTH) +: WIDTH];
      end
   end

   assign in_ready = grant;
   assign xfer     = |(grant & in_valid);
   assign rr_next  = (chosen == LAST_L) ? '0 : chosen + 1'b1;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
         rr_ptr    <= '0;
      end else if (xfer) begin
         out_data  <= xfer_data;
         out_ch    <= chosen;
         out_valid <= 1'b1;
         if (mode == MODE_RR) rr_ptr <= rr_next;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
